reset_seq_gen: RTL

RESET_SEQ_GEN -- requirements
Module: reset_seq_gen

---
 rtl/reset_seq_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/reset_seq_gen.sv
// Staggered reset release sequencer: channels leave reset one at a time, then done rises.
// Optional per-channel clock-enable dividers are built when RESET_SEQ_GEN_CE_EN is defined.
module reset_seq_gen #(
    parameter int NUM_CH         = 4,
    parameter int ASSERT_CYCLES  = 2,
    parameter int STAGGER_CYCLES = 4,
    parameter int DIV_W          = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    soft_rst,
    input  logic [NUM_CH*DIV_W-1:0] ce_div,
    output logic [NUM_CH-1:0]       rst_out,
    output logic [NUM_CH-1:0]       ce_out,
    output logic                    done
);

    localparam int MAX_CYC = (ASSERT_CYCLES > STAGGER_CYCLES) ? ASSERT_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0] rst_shift;
    logic              last_release;

    // Releases go in ascending channel order, so shifting left drops the lowest asserted channel.
    assign rst_shift    = rst_out << 1;
    assign last_release = (rst_shift == '0);

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || soft_rst) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            rst_out <= '1;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt == ASSERT_LAST) begin
                        rst_out <= rst_shift;
                        cnt     <= CNT_W'(1);
                        if (last_release) begin
                            state <= ST_RUN;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == STAGGER_LAST) begin
                        rst_out <= rst_shift;
                        cnt     <= CNT_W'(1);
                        if (last_release) begin
                            state <= ST_RUN;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    rst_out <= '0;
                    done    <= 1'b1;
                end
                default: begin
                    state   <= ST_ASSERT;
                    cnt     <= '0;
                    rst_out <= '1;
                    done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RESET_SEQ_GEN_CE_EN
    logic [DIV_W-1:0] div_cnt [NUM_CH];

    // A counter sits at 0 while its channel is in reset, so the first pulse lands
    // on the edge after release; each pulse reloads the current divide ratio.
    always_ff @(posedge clk) begin
        if (!rst_n || soft_rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                div_cnt[k] <= '0;
            end
            ce_out <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (rst_out[k]) begin
                    div_cnt[k] <= '0;
                    ce_out[k]  <= 1'b0;
                end else if (div_cnt[k] == '0) begin
                    div_cnt[k] <= ce_div[k*DIV_W +: DIV_W];
                    ce_out[k]  <= 1'b1;
                end else begin
                    div_cnt[k] <= div_cnt[k] - 1'b1;
                    ce_out[k]  <= 1'b0;
                end
            end
        end
    end
`else
    logic unused_ce_div;

    assign unused_ce_div = ^ce_div;
    assign ce_out        = ~rst_out;
`endif

endmodule
